// File: rtl/envelope_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : envelope_sequencer_if
//  Description : Command bus from the SPI slave to the envelope sequencer.
//                Carries the 16-bit command word, its strobe and the ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface envelope_sequencer_if;
   logic        cmd_valid;
   logic [15:0] cmd_data;
   logic        cmd_ready;

   modport master (output cmd_valid, output cmd_data, input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/envelope_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : envelope_sequencer
//  Description : Decodes 16-bit note/envelope commands and runs an ADSR
//                envelope on a prescaled tick, driving amp level, oscillator
//                pitch and a one-cycle oscillator restart pulse.
//                Optional macro CMD_CHANGE_DETECT_EN: accept a command whenever
//                the word changes instead of on cmd_valid strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module envelope_sequencer #(
   parameter int CLKSPEED = 48_000_000,
   parameter int TICK_HZ  = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   envelope_sequencer_if.slave  cmd,
   output logic [9:0]           amp,
   output logic [9:0]           freq_mod,
   output logic                 osc_restart,
   output logic                 gate,
   output logic [2:0]           state
);

   localparam int              c_period     = CLKSPEED / TICK_HZ;
   localparam int              c_pw         = (c_period > 1) ? $clog2(c_period) : 1;
   localparam logic [c_pw-1:0] c_presc_last = c_pw'(c_period - 1);

   localparam logic [3:0] c_op_note_on  = 4'h1;
   localparam logic [3:0] c_op_note_off = 4'h2;
   localparam logic [3:0] c_op_attack   = 4'h3;
   localparam logic [3:0] c_op_decay    = 4'h4;
   localparam logic [3:0] c_op_sustain  = 4'h5;
   localparam logic [3:0] c_op_release  = 4'h6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_t;

   env_state_t      r_state, w_state_nxt;
   logic [9:0]      r_amp, w_amp_nxt;
   logic            r_gate, w_gate_nxt;
   logic [c_pw-1:0] r_presc;
   logic            r_ready_pre, r_ready;
   logic [9:0]      r_attack, r_decay, r_sustain, r_release;
   logic [9:0]      r_freq;
   logic            r_osc_restart;

   logic            w_tick, w_accept, w_note_on, w_note_off;
   logic [3:0]      w_op;
   logic [9:0]      w_arg;
   logic [10:0]     w_attack_sum, w_above_sus;
   logic            unused_bits;

   assign w_tick = (r_presc == c_presc_last);
   assign w_op   = cmd.cmd_data[15:12];
   assign w_arg  = cmd.cmd_data[9:0];

`ifdef CMD_CHANGE_DETECT_EN
   logic [15:0] r_prev_data;

   // Previous word, only tracked once commands can be taken so nothing is lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_prev_data <= 16'h0000;
      else if (r_ready) r_prev_data <= cmd.cmd_data;
   end

   assign w_accept    = r_ready && (cmd.cmd_data != r_prev_data);
   assign unused_bits = ^{cmd.cmd_data[11:10], cmd.cmd_valid};
`else
   assign w_accept    = r_ready && cmd.cmd_valid;
   assign unused_bits = ^cmd.cmd_data[11:10];
`endif

   assign w_note_on  = w_accept && (w_op == c_op_note_on);
   assign w_note_off = w_accept && (w_op == c_op_note_off) &&
                       ((r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                        (r_state == ST_SUSTAIN));

   // 11-bit intermediates so neither direction can wrap before saturation
   assign w_attack_sum = {1'b0, r_amp} + {1'b0, r_attack};
   assign w_above_sus  = {1'b0, r_amp} - {1'b0, r_sustain};

   // Free-running tick prescaler, never disturbed by commands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 1'b1;
   end

   // Two-stage ready so commands open up on the second edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_pre <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         r_ready_pre <= 1'b1;
         r_ready     <= r_ready_pre;
      end
   end

   // Envelope state, level and gate registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_amp   <= 10'd0;
         r_gate  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_amp   <= w_amp_nxt;
         r_gate  <= w_gate_nxt;
      end
   end

   // Next envelope state; note events pre-empt the tick update of that cycle
   always_comb begin
      w_state_nxt = r_state;
      w_amp_nxt   = r_amp;
      w_gate_nxt  = r_gate;
      if (w_note_on) begin
         w_state_nxt = ST_ATTACK;
         w_gate_nxt  = 1'b1;
      end else if (w_note_off) begin
         w_state_nxt = ST_RELEASE;
         w_gate_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_ATTACK: if (w_tick) begin
               if ((r_attack == 10'd0) || (w_attack_sum >= 11'd1023)) begin
                  w_amp_nxt   = 10'd1023;
                  w_state_nxt = ST_DECAY;
               end else begin
                  w_amp_nxt = w_attack_sum[9:0];
               end
            end
            ST_DECAY: if (w_tick) begin
               if ((r_decay == 10'd0) || (r_amp <= r_sustain) ||
                   (w_above_sus <= {1'b0, r_decay})) begin
                  w_amp_nxt   = r_sustain;
                  w_state_nxt = ST_SUSTAIN;
               end else begin
                  w_amp_nxt = r_amp - r_decay;
               end
            end
            ST_SUSTAIN: w_amp_nxt = r_sustain;
            ST_RELEASE: if (w_tick) begin
               if ((r_release == 10'd0) || (r_amp <= r_release)) begin
                  w_amp_nxt   = 10'd0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_amp_nxt = r_amp - r_release;
               end
            end
            default: ;
         endcase
      end
   end

   // Command-loaded registers and the oscillator restart pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_attack      <= 10'd8;
         r_decay       <= 10'd4;
         r_sustain     <= 10'd768;
         r_release     <= 10'd2;
         r_freq        <= 10'd0;
         r_osc_restart <= 1'b0;
      end else begin
         r_osc_restart <= w_note_on;
         if (w_accept) begin
            case (w_op)
               c_op_note_on: r_freq    <= w_arg;
               c_op_attack:  r_attack  <= w_arg;
               c_op_decay:   r_decay   <= w_arg;
               c_op_sustain: r_sustain <= w_arg;
               c_op_release: r_release <= w_arg;
               default: ;
            endcase
         end
      end
   end

   assign cmd.cmd_ready = r_ready;
   assign amp           = r_amp;
   assign freq_mod      = r_freq;
   assign osc_restart   = r_osc_restart;
   assign gate          = r_gate;
   assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_envelope_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_envelope_sequencer
//  Description : Directed and random stimulus for envelope_sequencer with an
//                ADSR reference model evaluated once per clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_envelope_sequencer;
   localparam int CLKSPEED = 1000;
   localparam int TICK_HZ  = 100;
   localparam int PERIOD   = CLKSPEED / TICK_HZ;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] amp, freq_mod;
   logic       osc_restart, gate;
   logic [2:0] state;

   envelope_sequencer_if bus ();

   envelope_sequencer #(.CLKSPEED(CLKSPEED), .TICK_HZ(TICK_HZ)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (bus),
      .amp         (amp),
      .freq_mod    (freq_mod),
      .osc_restart (osc_restart),
      .gate        (gate),
      .state       (state)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state (levels as plain integers)
   int          m_amp, m_freq, m_state, m_att, m_dec, m_sus, m_rel, m_edges;
   bit          m_gate, m_restart, m_ready, m_tick;
   logic [15:0] m_prev;

   int tick_amps[$];
   int tick_states[$];
   bit record   = 1'b0;
   int restarts = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_amp = 0; m_freq = 0; m_state = 0; m_gate = 0; m_restart = 0;
      m_att = 8; m_dec = 4; m_sus = 768; m_rel = 2;
      m_edges = 0; m_ready = 0; m_prev = 16'h0000; m_tick = 0;
   endtask

   // Effect of one clock edge, from the pre-edge model state and inputs
   task automatic model_edge(input logic v, input logic [15:0] d);
      bit acc, on, off;
      int op, arg;
      m_tick = (m_edges % PERIOD) == PERIOD - 1;
`ifdef CMD_CHANGE_DETECT_EN
      acc = m_ready && (d != m_prev);
      if (m_ready) m_prev = d;
`else
      acc = m_ready && v;
`endif
      op  = int'(d[15:12]);
      arg = int'(d[9:0]);
      on  = acc && op == 1;
      off = acc && op == 2 && m_state >= 1 && m_state <= 3;
      if (on) begin
         m_state = 1; m_gate = 1;
      end else if (off) begin
         m_state = 4; m_gate = 0;
      end else begin
         if (m_state == 3) m_amp = m_sus;
         if (m_tick) begin
            case (m_state)
               1: begin
                  m_amp = (m_att == 0 || m_amp + m_att > 1023) ? 1023 : m_amp + m_att;
                  if (m_amp == 1023) m_state = 2;
               end
               2: begin
                  m_amp = (m_dec == 0 || m_amp - m_dec <= m_sus) ? m_sus : m_amp - m_dec;
                  if (m_amp == m_sus) m_state = 3;
               end
               4: begin
                  m_amp = (m_rel == 0 || m_amp <= m_rel) ? 0 : m_amp - m_rel;
                  if (m_amp == 0) m_state = 0;
               end
               default: ;
            endcase
         end
      end
      if (acc) begin
         case (op)
            1: m_freq = arg;
            3: m_att  = arg;
            4: m_dec  = arg;
            5: m_sus  = arg;
            6: m_rel  = arg;
            default: ;
         endcase
      end
      m_restart = on;
      m_edges++;
      m_ready = m_edges >= 2;
   endtask

   task automatic check_all();
      chk("amp", amp, m_amp);
      chk("state", state, m_state);
      chk("gate", gate, m_gate);
      chk("freq_mod", freq_mod, m_freq);
      chk("osc_restart", osc_restart, m_restart);
      chk("cmd_ready", bus.cmd_ready, m_ready);
   endtask

   task automatic step(input logic v, input logic [15:0] d);
      bus.cmd_valid = v;
      bus.cmd_data  = d;
      @(posedge clk);
      model_edge(v, d);
      #1;
      check_all();
      restarts += int'(osc_restart);
      if (record && m_tick) begin
         tick_amps.push_back(int'(amp));
         tick_states.push_back(int'(state));
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, bus.cmd_data);
   endtask

   task automatic send(input logic [15:0] w);
`ifdef CMD_CHANGE_DETECT_EN
      step(1'b0, w);
`else
      step(1'b1, w);
`endif
   endtask

   task automatic run_to_tick();
      for (int k = 0; k < PERIOD; k++) begin
         step(1'b0, bus.cmd_data);
         if (m_tick) break;
      end
   endtask

   int exp_amps[7]   = '{256, 512, 768, 1023, 923, 823, 768};
   int exp_states[7] = '{1, 1, 1, 2, 2, 2, 3};

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 16'h0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_all();
      @(negedge clk) rst_n = 1'b1;

      // ready opens on the second edge after release
      step(1'b0, 16'h0000);
      chk("ready_edge1", bus.cmd_ready, 0);
      step(1'b0, 16'h0000);
      chk("ready_edge2", bus.cmd_ready, 1);

      // asynchronous reset in the middle of an attack
      send(16'h3100);
      send(16'h1200);
      chk("first_restart", osc_restart, 1);
      for (int k = 0; k < 60 && amp !== 10'd512; k++) idle(1);
      chk("mid_attack_amp", amp, 512);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_amp", amp, 0);
      chk("async_state", state, 0);
      chk("async_gate", gate, 0);
      chk("async_ready", bus.cmd_ready, 0);
      bus.cmd_data = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      idle(2);
      chk("ready_after_reset", bus.cmd_ready, 1);

      // full attack / decay / sustain / release walk
      send(16'h3100);
      send(16'h4064);
      send(16'h5300);
      send(16'h6000);
      send(16'h1200);
      chk("note_on_freq", freq_mod, 10'h200);
      chk("note_on_gate", gate, 1);
      chk("note_on_pulse", osc_restart, 1);
      idle(1);
      chk("pulse_one_cycle", osc_restart, 0);
      tick_amps.delete();
      tick_states.delete();
      record = 1'b1;
      idle(8 * PERIOD);
      record = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("adsr_amp_tick%0d", i + 1),
             (i < tick_amps.size()) ? tick_amps[i] : -1, exp_amps[i]);
         chk($sformatf("adsr_state_tick%0d", i + 1),
             (i < tick_states.size()) ? tick_states[i] : -1, exp_states[i]);
      end
      send(16'h2000);
      chk("note_off_gate", gate, 0);
      chk("note_off_state", state, 4);
      run_to_tick();
      chk("instant_release_amp", amp, 0);
      chk("instant_release_state", state, 0);

      // retrigger from RELEASE at level 400
      send(16'h3064);
      send(16'h4064);
      send(16'h5190);
      send(16'h6032);
      send(16'h1201);
      for (int k = 0; k < 400 && state !== 3'd3; k++) idle(1);
      chk("reach_sustain_400", amp, 400);
      while (m_edges % PERIOD != 0) idle(1);
      send(16'h2000);
      chk("release_state", state, 4);
      chk("release_amp_hold", amp, 400);
      send(16'h1202);
      chk("retrig_state", state, 1);
      chk("retrig_pulse", osc_restart, 1);
      chk("retrig_amp_kept", amp, 400);
      run_to_tick();
      chk("retrig_amp_tick", amp, 500);

      // NOTE_ON landing on a tick skips that tick's update
      while (m_edges % PERIOD != PERIOD - 1) idle(1);
      send(16'h1203);
      chk("tick_skip_amp", amp, 500);
      run_to_tick();
      chk("after_skip_amp", amp, 600);

      // same word presented twice
      send(16'h2000);
      idle(2);
      restarts = 0;
`ifdef CMD_CHANGE_DETECT_EN
      for (int k = 0; k < 30; k++) step(1'b0, 16'h1200);
      chk("held_word_restarts", restarts, 1);
`else
      send(16'h1200);
      idle(3);
      send(16'h1200);
      idle(3);
      chk("strobed_word_restarts", restarts, 2);
`endif

      // randomized command traffic against the model
      for (int k = 0; k < 1500; k++) begin
         logic [15:0] w;
         logic [3:0]  op;
         logic [9:0]  arg;
         op  = 4'($urandom_range(0, 15));
         arg = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 300));
         if (op == 4'h5 || op == 4'h1) arg = 10'($urandom_range(0, 1023));
         w = {op, 2'($urandom_range(0, 3)), arg};
         if ($urandom_range(0, 99) < 20) begin
            send(w);
         end else begin
            idle(1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
